// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects and load-use stall for a 5-stage pipeline.
// Forward selects are registered so they line up with the operands sitting in EX.
module fwd_hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_ex_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o
);
    logic [REG_AW-1:0] ex_rd_q, mem_rd_q;
    logic              ex_rw_q, ex_mr_q, mem_rw_q;
    logic [1:0]        fwd_a_q, fwd_b_q;
    logic [1:0]        fwd_a_d, fwd_b_d;
    logic              ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, ex_live, mem_live;

    // The register file is write-through, so a WB producer never needs a select.
    always_comb begin
        ex_live   = ex_rw_q && (ex_rd_q != '0);
        mem_live  = mem_rw_q && (mem_rd_q != '0);
        ex_hit_a  = ex_live && (ex_rd_q == id_rs1_i);
        ex_hit_b  = ex_live && (ex_rd_q == id_rs2_i);
        mem_hit_a = mem_live && (mem_rd_q == id_rs1_i);
        mem_hit_b = mem_live && (mem_rd_q == id_rs2_i);
        fwd_a_d   = ex_hit_a ? 2'b10 : mem_hit_a ? 2'b01 : 2'b00;
        fwd_b_d   = ex_hit_b ? 2'b10 : mem_hit_b ? 2'b01 : 2'b00;
        stall_o   = rst_n && ex_mr_q && (ex_hit_a || ex_hit_b);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            fwd_a_q  <= 2'b00;
            fwd_b_q  <= 2'b00;
        end else begin
            mem_rd_q <= ex_rd_q;
            mem_rw_q <= ex_rw_q;
            if (flush_ex_i || stall_o) begin
                ex_rd_q <= '0;
                ex_rw_q <= 1'b0;
                ex_mr_q <= 1'b0;
                fwd_a_q <= 2'b00;
                fwd_b_q <= 2'b00;
            end else begin
                ex_rd_q <= id_rd_i;
                ex_rw_q <= id_regwrite_i;
                ex_mr_q <= id_memread_i;
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding selects and load-use stall.
module tb_fwd_hazard_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_regwrite, id_memread, flush_ex;
    logic [1:0] fwd_a, fwd_b;
    logic       stall;
    int         passed = 0;
    int         total = 0;

    fwd_hazard_unit #(.REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_ex_i(flush_ex),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush_ex = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        issue(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        issue(5'd3, 5'd9, 5'd3, 1'b1, 1'b1, 1'b1);
        tick();
        chk("rst_fwd_a", fwd_a, 2'b00);
        chk("rst_fwd_b", fwd_b, 2'b00);
        chk("rst_stall", {1'b0, stall}, 2'b00);
        rst_n = 1'b1;
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rel_fwd_a", fwd_a, 2'b00);
        chk("rel_fwd_b", fwd_b, 2'b00);

        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        issue(5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        chk("exmem_fwd_a", fwd_a, 2'b10);
        chk("exmem_fwd_b", fwd_b, 2'b00);

        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        issue(5'd3, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        chk("memwb_fwd_b", fwd_b, 2'b01);
        chk("memwb_fwd_a", fwd_a, 2'b00);

        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        issue(5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        chk("newest_fwd_a", fwd_a, 2'b10);

        issue(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        issue(5'd7, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", {1'b0, stall}, 2'b01);
        tick();
        chk("lu_bubble_a", fwd_a, 2'b00);
        chk("lu_stall_gone", {1'b0, stall}, 2'b00);
        tick();
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_fwd_b", fwd_b, 2'b00);

        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        issue(5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        chk("x0_fwd_a", fwd_a, 2'b00);
        chk("x0_fwd_b", fwd_b, 2'b00);
        issue(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        issue(5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
        chk("x0_no_stall", {1'b0, stall}, 2'b00);
        tick();

        issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1);
        tick();
        issue(5'd9, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
        tick();
        chk("flush_fwd_a", fwd_a, 2'b00);

        issue(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        issue(5'd7, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1);
        chk("fl_st_stall", {1'b0, stall}, 2'b01);
        tick();
        chk("fl_st_fwd_a", fwd_a, 2'b00);
        issue(5'd7, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0);
        chk("fl_st_restall", {1'b0, stall}, 2'b00);
        tick();
        chk("fl_st_after_a", fwd_a, 2'b01);

        issue(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        issue(5'd7, 5'd0, 5'd16, 1'b1, 1'b0, 1'b0);
        chk("rs_pre_stall", {1'b0, stall}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("rs_stall_drop", {1'b0, stall}, 2'b00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rs_clean_stall", {1'b0, stall}, 2'b00);
        tick();
        chk("rs_clean_fwd_a", fwd_a, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
